uart_tx_fifo: RTL and testbench

Buffered UART transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises each word onto one line as 8N1-style frames: one start bit, WORD data bits LSB first, no parity, and STOP_BITS stop bits. It is the transmit-side counterpart of the team's `uart_rx`. With identical `CLKS_PER_BIT` and `WORD`, its output is directly receivable by `uart_rx`.

---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (valid/ready word input, start/WORD data LSB-first/STOP_BITS stop serial output, done pulse, fill count)
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int WORD = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_Valid,
  output logic                          o_Tx_Ready,
  input  logic [WORD-1:0]               i_Tx_Byte,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = WORD == 1 ? 1 : $clog2(WORD);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_AT = CW'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] LAST_BIT = IW'(WORD - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [WORD-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] clk_cnt;
  logic [IW-1:0] bit_idx;
  logic [WORD-1:0] shift;
  logic push, pop, frame_end;
  logic [AW:0] next_count;
  always_comb begin
    push = i_Tx_Valid && o_Tx_Ready;
    frame_end = state == STOP && clk_cnt == STOP_END;
    pop = o_Fifo_Count != '0 && (state == IDLE || frame_end);
    next_count = o_Fifo_Count + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge i_Clock)
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state <= IDLE;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done <= 1'b0;
      o_Tx_Ready <= 1'b0;
      o_Fifo_Count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      o_Fifo_Count <= next_count;
      o_Tx_Ready <= !next_count[AW];
      o_Tx_Done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shift <= mem[rd_ptr];
      end
      case (state)
        IDLE: begin
          state <= pop ? START : IDLE;
          clk_cnt <= '0;
          o_Tx_Serial <= !pop;
          o_Tx_Active <= pop;
        end
        START:
          if (clk_cnt == BIT_END) begin
            state <= DATA;
            clk_cnt <= '0;
            bit_idx <= '0;
            o_Tx_Serial <= shift[0];
          end else clk_cnt <= clk_cnt + 1'b1;
        DATA:
          if (clk_cnt == BIT_END) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              o_Tx_Serial <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              o_Tx_Serial <= shift[bit_idx + 1'b1];
            end
          end else clk_cnt <= clk_cnt + 1'b1;
        STOP:
          if (frame_end) begin
            state <= pop ? START : IDLE;
            clk_cnt <= '0;
            o_Tx_Serial <= !pop;
            o_Tx_Active <= pop;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
            o_Tx_Done <= clk_cnt == DONE_AT;
          end
        default: begin
          state <= IDLE;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench comparing whole serial frames against an ideal line model
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int F1 = CPB * 10;
  localparam int F2 = CPB * 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0, valid2 = 1'b0;
  logic [7:0] data = '0, data2 = '0;
  logic ready, serial, active, done, ready2, serial2, active2, done2;
  logic [2:0] count, count2;
  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0, first_done = -1, start_wait = 0;
  logic [7:0] exp_q [$];
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .WORD(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_Valid(valid), .o_Tx_Ready(ready), .i_Tx_Byte(data),
    .o_Tx_Serial(serial), .o_Tx_Active(active), .o_Tx_Done(done), .o_Fifo_Count(count));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .WORD(8), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_Valid(valid2), .o_Tx_Ready(ready2), .i_Tx_Byte(data2),
    .o_Tx_Serial(serial2), .o_Tx_Active(active2), .o_Tx_Done(done2), .o_Fifo_Count(count2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] frame_bits(input logic [7:0] w, input int stop);
    logic [63:0] f = '1;
    for (int i = 0; i < CPB * (9 + stop); i++)
      f[i] = (i < CPB) ? 1'b0 : (i < CPB * 9) ? w[i / CPB - 1] : 1'b1;
    return f;
  endfunction
  task automatic push_word(input logic [7:0] w);
    int t = 0;
    valid = 1'b1;
    data = w;
    while (ready !== 1'b1 && t < 200) begin
      tick;
      t++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL push_timeout ready=%b required=1", ready);
    end else begin
      @(posedge clk);
      exp_q.push_back(w);
      #1;
      acc_cyc = cyc;
    end
    valid = 1'b0;
  endtask
  task automatic check_frames(input int n);
    int t = 0;
    logic [63:0] ln, dn, ac;
    logic [7:0] w;
    while (serial !== 1'b0 && t < 200) begin
      tick;
      t++;
    end
    start_wait = t;
    checks++;
    if (serial !== 1'b0) begin
      failures++;
      $display("FAIL start_timeout serial=%b required=0", serial);
      return;
    end
    for (int f = 0; f < n; f++) begin
      ln = '1;
      dn = '0;
      ac = '0;
      for (int i = 0; i < F1; i++) begin
        ln[i] = serial;
        dn[i] = done;
        ac[i] = active;
        if (done === 1'b1 && first_done < 0) first_done = cyc;
        tick;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL frame_unexpected frame=%0d line=%h required=no frame", f, ln);
        continue;
      end
      w = exp_q.pop_front();
      checks += 3;
      if (ln !== frame_bits(w, 1)) begin
        failures++;
        $display("FAIL frame_line word=%h got=%h required=%h", w, ln, frame_bits(w, 1));
      end
      if (dn !== 64'(1) << (F1 - 1)) begin
        failures++;
        $display("FAIL frame_done word=%h got=%h required=%h", w, dn, 64'(1) << (F1 - 1));
      end
      if (ac !== (64'(1) << F1) - 1) begin
        failures++;
        $display("FAIL frame_active word=%h got=%h required=%h", w, ac, (64'(1) << F1) - 1);
      end
    end
    checks++;
    if (serial !== 1'b1 || active !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL idle_after serial=%b active=%b left=%0d required 1 0 0", serial, active, exp_q.size());
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    valid = 1'b1;
    data = 8'h77;
    repeat (3) tick;
    checks += 4;
    if (serial !== 1'b1) begin failures++; $display("FAIL rst_serial got=%b required=1", serial); end
    if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b required=0", ready); end
    if (active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b required=0", active); end
    if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d required=0", count); end
    rst_n = 1'b1;
    tick;
    valid = 1'b0;
    checks += 2;
    if (ready !== 1'b1 || ready2 !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b%b required=11", ready, ready2); end
    if (count !== 3'd0) begin failures++; $display("FAIL rel_count got=%0d required=0", count); end
    tick;
    checks++;
    if (serial !== 1'b1 || count !== 3'd0) begin
      failures++;
      $display("FAIL rel_no_accept serial=%b count=%0d required 1 0", serial, count);
    end
  endtask
  task automatic test_single;
    push_word(8'hA5);
    checks++;
    if (serial !== 1'b1 || count !== 3'd1) begin
      failures++;
      $display("FAIL single_accept serial=%b count=%0d required 1 1", serial, count);
    end
    check_frames(1);
    checks++;
    if (start_wait != 1) begin failures++; $display("FAIL single_latency got=%0d required=1", start_wait); end
  endtask
  task automatic test_back_to_back;
    fork
      begin
        push_word(8'h00);
        push_word(8'hFF);
        push_word(8'h55);
      end
      check_frames(3);
    join
  endtask
  task automatic test_full_fifo;
    logic [7:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    first_done = -1;
    fork
      begin
        for (int i = 0; i < 5; i++) push_word(w[i]);
        checks += 2;
        if (ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b required=0", ready); end
        if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d required=4", count); end
        push_word(w[5]);
      end
      check_frames(6);
    join
    checks++;
    if (acc_cyc - first_done < 1 || acc_cyc - first_done > 2) begin
      failures++;
      $display("FAIL full_refill delay=%0d required 1..2", acc_cyc - first_done);
    end
  endtask
  task automatic test_mid_reset;
    logic bad = 1'b0;
    push_word(8'hC3);
    push_word(8'h11);
    repeat (17) tick;
    checks++;
    if (serial !== 1'b0) begin failures++; $display("FAIL mid_bit3 got=%b required=0", serial); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_q.delete();
    checks += 3;
    if (serial !== 1'b1) begin failures++; $display("FAIL mid_serial got=%b required=1", serial); end
    if (count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d required=0", count); end
    if (done !== 1'b0 || active !== 1'b0) begin failures++; $display("FAIL mid_done_active got=%b%b required=00", done, active); end
    for (int i = 0; i < 48; i++) begin
      if (serial !== 1'b1 || done !== 1'b0) bad = 1'b1;
      tick;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL mid_quiet got=activity required=idle line"); end
    push_word(8'h3C);
    check_frames(1);
  endtask
  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 5);
      fork
        for (int i = 0; i < n; i++) push_word(8'($urandom));
        check_frames(n);
      join
      repeat ($urandom_range(0, 5)) tick;
    end
  endtask
  task automatic test_two_stop;
    int t = 0;
    logic [63:0] ln = '1, dn = '0, ac = '0;
    valid2 = 1'b1;
    data2 = 8'h81;
    checks++;
    if (ready2 !== 1'b1) begin failures++; $display("FAIL two_ready got=%b required=1", ready2); end
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    while (serial2 !== 1'b0 && t < 20) begin
      tick;
      t++;
    end
    for (int i = 0; i < F2; i++) begin
      ln[i] = serial2;
      dn[i] = done2;
      ac[i] = active2;
      tick;
    end
    checks += 4;
    if (ln !== frame_bits(8'h81, 2)) begin failures++; $display("FAIL two_line got=%h required=%h", ln, frame_bits(8'h81, 2)); end
    if (dn !== 64'(1) << (F2 - 1)) begin failures++; $display("FAIL two_done got=%h required=%h", dn, 64'(1) << (F2 - 1)); end
    if (ac !== (64'(1) << F2) - 1) begin failures++; $display("FAIL two_active got=%h required=%h", ac, (64'(1) << F2) - 1); end
    if (serial2 !== 1'b1 || active2 !== 1'b0 || count2 !== 3'd0) begin
      failures++;
      $display("FAIL two_idle serial=%b active=%b count=%0d required 1 0 0", serial2, active2, count2);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_full_fifo;
    test_mid_reset;
    test_random;
    test_two_stop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
